// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store front-end for the word-addressed data RAM.
// Turns byte-addressed LB/LBU/LH/LHU/LW/SB/SH/SW requests into RAM word
// accesses. Sub-word stores are done as a read-modify-write. Loads are
// sign- or zero-extended. Misaligned, out-of-range and illegal-size
// requests are flagged on o_err.
module mem_access_unit #(
  parameter int ADDRESS_SIZE = 32,
  parameter int DATA_SIZE    = 32,
  parameter int RAM_WORDS    = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_req,
  input  logic                    i_we,
  input  logic [1:0]              i_size,
  input  logic                    i_unsigned,
  input  logic [ADDRESS_SIZE-1:0] i_addr,
  input  logic [DATA_SIZE-1:0]    i_wdata,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_err,
  output logic [DATA_SIZE-1:0]    o_rdata,
  output logic [ADDRESS_SIZE-1:0] o_ram_addr,
  output logic [DATA_SIZE-1:0]    o_ram_wdata,
  output logic                    o_ram_we,
  input  logic [DATA_SIZE-1:0]    i_ram_rdata
);

  typedef enum logic [2:0] {IDLE, READ, MERGE, WRITE, DONE} state_t;

  localparam logic [ADDRESS_SIZE-1:0] RAM_LIMIT = ADDRESS_SIZE'(RAM_WORDS);

  state_t                  state;
  logic                    we_q;
  logic [1:0]              size_q;
  logic                    uns_q;
  logic [ADDRESS_SIZE-1:0] addr_q;
  logic [DATA_SIZE-1:0]    wdata_q;
  logic [DATA_SIZE-1:0]    buf_q;

  // A request is bad if it is misaligned for its size, uses the reserved
  // size code, or lands past the end of the attached RAM.
  function automatic logic is_error(input logic [1:0] size,
                                    input logic [ADDRESS_SIZE-1:0] addr);
    logic [ADDRESS_SIZE-1:0] word_index;
    word_index = {2'b00, addr[ADDRESS_SIZE-1:2]};
    is_error = (size == 2'b11)
            || ((size == 2'b01) && addr[0])
            || ((size == 2'b10) && (addr[1:0] != 2'b00))
            || (word_index >= RAM_LIMIT);
  endfunction

  // Pick the addressed lane out of a little-endian word and extend it.
  function automatic logic [DATA_SIZE-1:0] extract(input logic [DATA_SIZE-1:0] word,
                                                   input logic [1:0] size,
                                                   input logic [1:0] offset,
                                                   input logic zero_ext);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{offset, 3'b000} +: 8];
    h = word[{offset[1], 4'b0000} +: 16];
    case (size)
      2'b00:   extract = zero_ext ? {{(DATA_SIZE-8){1'b0}}, b}
                                  : {{(DATA_SIZE-8){b[7]}}, b};
      2'b01:   extract = zero_ext ? {{(DATA_SIZE-16){1'b0}}, h}
                                  : {{(DATA_SIZE-16){h[15]}}, h};
      default: extract = word;
    endcase
  endfunction

  // Overlay the right-aligned store data onto the addressed lane(s).
  function automatic logic [DATA_SIZE-1:0] merge(input logic [DATA_SIZE-1:0] word,
                                                 input logic [DATA_SIZE-1:0] data,
                                                 input logic [1:0] size,
                                                 input logic [1:0] offset);
    logic [DATA_SIZE-1:0] result;
    result = word;
    case (size)
      2'b00:   result[{offset, 3'b000} +: 8]     = data[7:0];
      2'b01:   result[{offset[1], 4'b0000} +: 16] = data[15:0];
      default: result = data;
    endcase
    merge = result;
  endfunction

  assign o_busy = (state != IDLE);

  // Request sequencer: every output except o_busy is registered here so the
  // RAM port and the completion strobe change only on clock edges (or reset).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      we_q        <= 1'b0;
      size_q      <= 2'b00;
      uns_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      buf_q       <= '0;
      o_done      <= 1'b0;
      o_err       <= 1'b0;
      o_rdata     <= '0;
      o_ram_addr  <= '0;
      o_ram_wdata <= '0;
      o_ram_we    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_req) begin
            we_q       <= i_we;
            size_q     <= i_size;
            uns_q      <= i_unsigned;
            addr_q     <= i_addr;
            wdata_q    <= i_wdata;
            o_ram_addr <= {2'b00, i_addr[ADDRESS_SIZE-1:2]};
            if (i_we && (i_size == 2'b10) && !is_error(i_size, i_addr)) begin
              o_ram_wdata <= i_wdata;
              o_ram_we    <= 1'b1;
              state       <= WRITE;
            end else begin
              state <= READ;
            end
          end
        end
        READ: begin
          if (is_error(size_q, addr_q)) begin
            o_err  <= 1'b1;
            o_done <= 1'b1;
            state  <= DONE;
          end else begin
            buf_q <= i_ram_rdata;
            if (we_q) begin
              state <= MERGE;
            end else begin
              o_rdata <= extract(i_ram_rdata, size_q, addr_q[1:0], uns_q);
              o_done  <= 1'b1;
              state   <= DONE;
            end
          end
        end
        MERGE: begin
          o_ram_wdata <= merge(buf_q, wdata_q, size_q, addr_q[1:0]);
          o_ram_we    <= 1'b1;
          state       <= WRITE;
        end
        WRITE: begin
          o_ram_we <= 1'b0;
          o_done   <= 1'b1;
          state    <= DONE;
        end
        DONE: begin
          o_done <= 1'b0;
          o_err  <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: drives mem_access_unit against a behavioural RAM and
// a byte-lane reference model, with directed and randomized requests.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        uns;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] rdata;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic        ram_we;
  logic [31:0] ram_rdata;

  logic [31:0] mem       [256];
  logic [31:0] model_mem [256];
  logic [31:0] model_rdata;

  int          errors = 0;
  int          checks = 0;

  int          exp_lat;
  logic        exp_err;
  int          exp_we_cycles;
  logic [31:0] exp_ram_addr;

  int          obs_lat;
  logic        obs_err;
  logic [31:0] obs_rdata;
  int          obs_we_cycles;
  int          obs_busy_gaps;
  logic [31:0] obs_ram_addr;
  logic        obs_done0;

  mem_access_unit #(.ADDRESS_SIZE(32), .DATA_SIZE(32), .RAM_WORDS(256)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_req       (req),
    .i_we        (we),
    .i_size      (size),
    .i_unsigned  (uns),
    .i_addr      (addr),
    .i_wdata     (wdata),
    .o_busy      (busy),
    .o_done      (done),
    .o_err       (err),
    .o_rdata     (rdata),
    .o_ram_addr  (ram_addr),
    .o_ram_wdata (ram_wdata),
    .o_ram_we    (ram_we),
    .i_ram_rdata (ram_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural RAM: combinational read, write committed on the falling edge.
  assign ram_rdata = (ram_addr < 32'd256) ? mem[ram_addr[7:0]] : 32'h0;

  always @(negedge clk) begin
    if (ram_we && (ram_addr < 32'd256)) mem[ram_addr[7:0]] = ram_wdata;
  end

  // Preload one word into both the RAM and the reference copy.
  task automatic set_word(input int idx, input logic [31:0] val);
    mem[idx]       = val;
    model_mem[idx] = val;
  endtask

  // Reference model working on bytes: decides error, latency and RAM write
  // count from the request rules, and updates the expected RAM/read result.
  task automatic model_op(input logic lwe, input logic [1:0] lsize, input logic luns,
                          input logic [31:0] laddr, input logic [31:0] lwdata);
    int          idx;
    int          off;
    int          nbytes;
    logic [31:0] w;
    logic [63:0] val;
    logic [63:0] mask;
    idx    = int'(laddr >> 2);
    off    = int'(laddr % 4);
    nbytes = (lsize == 2'd0) ? 1 : (lsize == 2'd1) ? 2 : 4;
    exp_err = (lsize == 2'd3) || (lsize == 2'd1 && (laddr % 2) != 0)
           || (lsize == 2'd2 && off != 0) || (idx >= 256);
    exp_lat       = (exp_err || !lwe || lsize == 2'd2) ? 2 : 4;
    exp_we_cycles = (lwe && !exp_err) ? 1 : 0;
    exp_ram_addr  = laddr >> 2;
    if (!exp_err) begin
      w = model_mem[idx];
      if (!lwe) begin
        val  = {32'h0, w} >> (8 * off);
        mask = (64'd1 << (8 * nbytes)) - 64'd1;
        val  = val & mask;
        if (!luns && nbytes < 4 && val[8*nbytes-1]) val = val | ~mask;
        model_rdata = val[31:0];
      end else begin
        for (int i = 0; i < nbytes; i++) w[8*(off+i) +: 8] = lwdata[8*i +: 8];
        model_mem[idx] = w;
      end
    end
  endtask

  // Issue one request and record what the DUT did. Cycle 0 is the idle cycle
  // in which the request is presented; completion is looked for up to 20
  // cycles later. With hold=1 the strobe is left high afterwards.
  task automatic applyStimulus(input logic lwe, input logic [1:0] lsize, input logic luns,
                               input logic [31:0] laddr, input logic [31:0] lwdata,
                               input logic hold);
    int waited;
    model_op(lwe, lsize, luns, laddr, lwdata);
    req = 1'b1; we = lwe; size = lsize; uns = luns; addr = laddr; wdata = lwdata;
    obs_lat = -1; obs_err = 1'b0; obs_rdata = 32'h0; obs_we_cycles = 0;
    obs_busy_gaps = 0; obs_ram_addr = 32'h0; obs_done0 = 1'b0;
    waited = 0;
    @(negedge clk);
    while (busy && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (busy) begin
      if (!hold) req = 1'b0;
      return;
    end
    obs_done0 = done;
    @(posedge clk);
    #1;
    if (!hold) req = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (ram_we) obs_we_cycles++;
      if (!busy) obs_busy_gaps++;
      if (done) begin
        obs_lat      = c;
        obs_err      = err;
        obs_rdata    = rdata;
        obs_ram_addr = ram_addr;
        break;
      end
    end
  endtask

  // Outputs while reset is held.
  task automatic test_reset;
    rst = 1'b1; req = 1'b0; we = 1'b0; size = 2'b00; uns = 1'b0;
    addr = 32'h0; wdata = 32'h0; model_rdata = 32'h0;
    for (int i = 0; i < 256; i++) set_word(i, 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %b want 0", done); end
    checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err got %b want 0", err); end
    checks++; if (ram_we !== 1'b0) begin errors++; $display("[TB] FAIL reset_ram_we got %b want 0", ram_we); end
    checks++; if (rdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_rdata got %h want 0", rdata); end
    checks++; if (ram_addr !== 32'h0) begin errors++; $display("[TB] FAIL reset_ram_addr got %h want 0", ram_addr); end
    checks++; if (ram_wdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_ram_wdata got %h want 0", ram_wdata); end
    rst = 1'b0;
  endtask

  // Hand-picked loads, stores and error cases around RAM word 5.
  task automatic test_directed;
    logic        t_pre  [10] = '{1, 1, 0, 1, 0, 0, 0, 0, 0, 0};
    logic [31:0] t_pval [10] = '{32'h11223344, 32'h11223384, 0, 32'h11223344, 0, 0, 0, 0, 0, 0};
    logic        t_we   [10] = '{0, 0, 0, 1, 1, 0, 0, 1, 0, 0};
    logic [1:0]  t_size [10] = '{2, 0, 0, 0, 1, 2, 1, 1, 1, 3};
    logic        t_uns  [10] = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
    logic [31:0] t_addr [10] = '{32'h14, 32'h14, 32'h14, 32'h16, 32'h13, 32'h400,
                                 32'h16, 32'h14, 32'h14, 32'h14};
    logic [31:0] t_wd   [10] = '{0, 0, 0, 32'hAB, 32'hBEEF, 0, 0, 32'h12348001, 0, 0};
    for (int i = 0; i < 10; i++) begin
      if (t_pre[i]) set_word(5, t_pval[i]);
      applyStimulus(t_we[i], t_size[i], t_uns[i], t_addr[i], t_wd[i], 1'b0);
      checks++; if (obs_lat !== exp_lat) begin errors++; $display("[TB] FAIL dir%0d_latency got %0d want %0d", i, obs_lat, exp_lat); end
      checks++; if (obs_err !== exp_err) begin errors++; $display("[TB] FAIL dir%0d_err got %b want %b", i, obs_err, exp_err); end
      checks++; if (obs_rdata !== model_rdata) begin errors++; $display("[TB] FAIL dir%0d_rdata got %h want %h", i, obs_rdata, model_rdata); end
      checks++; if (obs_we_cycles !== exp_we_cycles) begin errors++; $display("[TB] FAIL dir%0d_ram_we_cycles got %0d want %0d", i, obs_we_cycles, exp_we_cycles); end
      checks++; if (obs_ram_addr !== exp_ram_addr) begin errors++; $display("[TB] FAIL dir%0d_ram_addr got %h want %h", i, obs_ram_addr, exp_ram_addr); end
      checks++; if (obs_busy_gaps !== 0) begin errors++; $display("[TB] FAIL dir%0d_busy_gaps got %0d want 0", i, obs_busy_gaps); end
      checks++; if (mem[5] !== model_mem[5]) begin errors++; $display("[TB] FAIL dir%0d_ram5 got %h want %h", i, mem[5], model_mem[5]); end
    end
  endtask

  // Async reset landing in the write cycle of a byte store must suppress it.
  task automatic test_reset_mid_write;
    int waited;
    set_word(9, 32'hCAFEF00D);
    req = 1'b1; we = 1'b1; size = 2'b00; uns = 1'b0; addr = 32'h25; wdata = 32'h55;
    waited = 0;
    @(negedge clk);
    while (busy && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    @(posedge clk); #1; req = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if (ram_we !== 1'b1) begin errors++; $display("[TB] FAIL rstw_we_before got %b want 1", ram_we); end
    rst = 1'b1;
    #1;
    checks++; if (ram_we !== 1'b0) begin errors++; $display("[TB] FAIL rstw_we_after got %b want 0", ram_we); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rstw_busy got %b want 0", busy); end
    @(negedge clk); #1;
    checks++; if (mem[9] !== model_mem[9]) begin errors++; $display("[TB] FAIL rstw_ram9 got %h want %h", mem[9], model_mem[9]); end
    model_rdata = 32'h0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Randomized mix of sizes, directions, offsets and out-of-range addresses.
  task automatic test_random;
    logic        r_we;
    logic [1:0]  r_size;
    logic        r_uns;
    logic [31:0] r_addr;
    int          pick;
    for (int i = 0; i < 16; i++) set_word(i, $urandom);
    for (int i = 0; i < 60; i++) begin
      r_we = 1'($urandom_range(0, 1));
      r_uns = 1'($urandom_range(0, 1));
      pick = int'($urandom_range(0, 9));
      r_size = (pick < 3) ? 2'd0 : (pick < 6) ? 2'd1 : (pick < 9) ? 2'd2 : 2'd3;
      pick = int'($urandom_range(0, 9));
      if (pick == 0)      r_addr = 32'h400 + 32'($urandom_range(0, 255));
      else if (pick == 1) r_addr = 32'h8000_0000 | 32'($urandom_range(0, 63));
      else                r_addr = 32'($urandom_range(0, 63));
      applyStimulus(r_we, r_size, r_uns, r_addr, $urandom, 1'b0);
      checks++; if (obs_lat !== exp_lat) begin errors++; $display("[TB] FAIL rand%0d_latency got %0d want %0d", i, obs_lat, exp_lat); end
      checks++; if (obs_err !== exp_err) begin errors++; $display("[TB] FAIL rand%0d_err got %b want %b", i, obs_err, exp_err); end
      checks++; if (obs_rdata !== model_rdata) begin errors++; $display("[TB] FAIL rand%0d_rdata got %h want %h", i, obs_rdata, model_rdata); end
      checks++; if (obs_we_cycles !== exp_we_cycles) begin errors++; $display("[TB] FAIL rand%0d_ram_we_cycles got %0d want %0d", i, obs_we_cycles, exp_we_cycles); end
      checks++; if (obs_ram_addr !== exp_ram_addr) begin errors++; $display("[TB] FAIL rand%0d_ram_addr got %h want %h", i, obs_ram_addr, exp_ram_addr); end
    end
    for (int i = 0; i < 16; i++) begin
      checks++; if (mem[i] !== model_mem[i]) begin errors++; $display("[TB] FAIL rand_ram%0d got %h want %h", i, mem[i], model_mem[i]); end
    end
  endtask

  // Strobe held high: each op must start only from idle, one done per op.
  task automatic test_back_to_back;
    int late_done;
    logic [1:0] b_size [4] = '{2'd2, 2'd0, 2'd1, 2'd2};
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'(i % 2), b_size[i % 4], 1'($urandom_range(0, 1)),
                    32'((i % 8) * 4 + ((b_size[i % 4] == 2'd0) ? (i % 4) : 0)), $urandom, 1'b1);
      checks++; if (obs_lat !== exp_lat) begin errors++; $display("[TB] FAIL b2b%0d_latency got %0d want %0d", i, obs_lat, exp_lat); end
      checks++; if (obs_done0 !== 1'b0) begin errors++; $display("[TB] FAIL b2b%0d_done_in_idle got %b want 0", i, obs_done0); end
      checks++; if (obs_rdata !== model_rdata) begin errors++; $display("[TB] FAIL b2b%0d_rdata got %h want %h", i, obs_rdata, model_rdata); end
      checks++; if (obs_we_cycles !== exp_we_cycles) begin errors++; $display("[TB] FAIL b2b%0d_ram_we_cycles got %0d want %0d", i, obs_we_cycles, exp_we_cycles); end
      checks++; if (obs_busy_gaps !== 0) begin errors++; $display("[TB] FAIL b2b%0d_busy_gaps got %0d want 0", i, obs_busy_gaps); end
    end
    req = 1'b0;
    late_done = 0;
    repeat (4) begin
      @(negedge clk);
      if (done || busy) late_done++;
    end
    checks++; if (late_done !== 0) begin errors++; $display("[TB] FAIL b2b_activity_after_release got %0d want 0", late_done); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (mem[i] !== model_mem[i]) begin errors++; $display("[TB] FAIL b2b_ram%0d got %h want %h", i, mem[i], model_mem[i]); end
    end
  endtask

  // Test sequence.
  initial begin
    test_reset;
    test_directed;
    test_reset_mid_write;
    test_random;
    test_back_to_back;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store front-end that sits directly upstream of the word-addressed data RAM in the single-issue MIPS datapath.
- Accepts byte-addressed LB/LBU/LH/LHU/LW/SB/SH/SW requests from the pipeline and converts them to RAM word indices.
- Sub-word stores are done as read-modify-write over the full-word RAM port.
- Loads are sign- or zero-extended, and misaligned or out-of-range accesses are flagged.

Parameters:
- ADDRESS_SIZE, 32, width of the byte address and of the RAM address port.
- DATA_SIZE, 32, data word width; fixed at 32 because lane logic assumes 4 byte lanes.
- RAM_WORDS, 256, number of words in the attached RAM; word index must be < RAM_WORDS.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- i_req  input  1  request strobe; sampled only in IDLE.
- i_we  input  1  1 = store, 0 = load.
- i_size  input  2  00 byte, 01 halfword, 10 word; 11 is treated as an error.
- i_unsigned  input  1  load zero-extend when 1, sign-extend when 0; ignored for stores and word loads.
- i_addr  input  ADDRESS_SIZE  byte address.
- i_wdata  input  DATA_SIZE  store data, right-aligned: byte in [7:0], half in [15:0].
- o_busy  output  1  high whenever state != IDLE.
- o_done  output  1  one-cycle completion pulse.
- o_err  output  1  valid with o_done; misaligned, out-of-range or illegal size.
- o_rdata  output  DATA_SIZE  extended load result; updated on load completion, held otherwise.
- o_ram_addr  output  ADDRESS_SIZE  word index = registered addr[31:2], zero-extended.
- o_ram_wdata  output  DATA_SIZE  full word written to RAM.
- o_ram_we  output  1  RAM write enable; the RAM commits on the falling edge inside the cycle.
- i_ram_rdata  input  DATA_SIZE  combinational RAM read data for o_ram_addr.

Behaviour:
- Reset values: state IDLE; o_busy, o_done, o_err, o_ram_we = 0; o_rdata, o_ram_addr, o_ram_wdata = 0. Reset asserted mid-operation drops o_ram_we immediately (async) and no further RAM write occurs.
- Byte order is little-endian. Lane k = bits [8k+7:8k] selected by addr[1:0] = k. Halfword lane h = bits [16h+15:16h] selected by addr[1].
- In IDLE with i_req=1, register i_we, i_size, i_unsigned, i_addr and i_wdata.
- Error check is done on the registered request:
  - size 01 with addr[0] = 1 is an error.
  - size 10 with addr[1:0] != 0 is an error.
  - size 11 is an error.
  - addr[31:2] >= RAM_WORDS is an error.
- FSM states: IDLE, READ, MERGE, WRITE, DONE.
  - IDLE --req--> READ when (load) or (store with size != word) or (error); IDLE --req--> WRITE for a store word.
  - READ: if error, go to DONE with err=1 and no RAM write. Otherwise capture i_ram_rdata into the word buffer; a load goes to DONE, a sub-word store goes to MERGE.
  - MERGE: replace the selected lane(s) of the buffer with i_wdata low bits, then go to WRITE.
  - WRITE: o_ram_we = 1 for exactly this one cycle, with o_ram_wdata = merged buffer (sub-word) or i_wdata (word). Go to DONE.
  - DONE: o_done = 1 for one cycle and o_err valid. For a load without error, o_rdata = extracted lane, extended, valid from this cycle. Go to IDLE.
- Latency, counting the request cycle as 0 and giving the cycle in which o_done is high:
  - Load: 2.
  - Store word: 2.
  - Store byte/half: 4.
  - Any error: 2.
- i_req while busy is ignored (not queued). The next request can be accepted only in the cycle after DONE.
- A load error leaves o_rdata at its previous value.
- A store error leaves RAM untouched, and o_ram_we never asserts.
- o_ram_addr is held constant from READ/WRITE entry through DONE.

Test Plan:
- After reset, RAM[5] = 0x11223344; request load word at addr 0x14 -> o_done in cycle 2, o_rdata = 0x11223344, o_err = 0, o_ram_we never high.
- RAM[5] = 0x11223384; load byte at addr 0x14 signed -> o_rdata = 0xFFFFFF84; the same load unsigned -> o_rdata = 0x00000084.
- RAM[5] = 0x11223344; store byte 0xAB at addr 0x16 -> o_done in cycle 4, o_ram_we high exactly one cycle, RAM[5] = 0x11AB3344.
- Store half 0xBEEF at addr 0x13 (misaligned) -> o_done in cycle 2 with o_err = 1, RAM unchanged; load at addr 0x400 (index 256) -> o_err = 1, o_rdata unchanged.
- Assert rst during the WRITE cycle of a byte store -> o_ram_we falls immediately, RAM word unchanged, o_busy = 0.
- Hold i_req high continuously with alternating ops -> each op is accepted only from IDLE, with no overlap and no dropped o_done pulse.
